la_capture_wb: RTL

- Logic-analyzer capture core and Wishbone slave. Sits directly downstream of the serial debug controller's Wishbone master port.
- Samples a 32-bit probe bus into a circular buffer. Triggers on a mask/value match and stops after a programmed number of post-trigger samples.
- The host reads status and samples back over Wishbone.

---
 rtl/la_capture_wb.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/la_capture_wb.sv
// la_capture_wb: logic-analyzer capture buffer behind a Wishbone classic slave.
// Optional LA_EDGE_TRIG_EN adds EDGE_MASK (index 3, POST_CNT moves to 4) and an edge-qualified trigger.
//
// state | meaning
// IDLE  | not sampling, wr_ptr held
// ARMED | sampling every cycle, waiting for trigger
// POST  | sampling post-trigger samples, post counter running
// DONE  | capture frozen, done_o high
module la_capture_wb #(
  parameter int ADDR_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] probe_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic        done_o
);
  localparam int DEPTH = 2**ADDR_W;
`ifdef LA_EDGE_TRIG_EN
  localparam int IDX_W    = 3;
  localparam int POST_IDX = 4;
`else
  localparam int IDX_W    = 2;
  localparam int POST_IDX = 3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;
  state_t state_q, state_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] wr_ptr_q, trig_ptr_q, post_cnt_q, post_len_q, rd_addr;
  logic [31:0]       trig_mask_q, trig_value_q, reg_rd;
  logic [ADDR_W:0]   adr_q;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              stg1_q, stg2_q;
  logic              accept, reg_wr, arm_req, abort_req;
  logic              trig_match, sample, trig_hit;
  logic              unused_ok;

  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:ADDR_W+3], wbs_adr_i[1:0]};

  assign accept    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~stg1_q & ~stg2_q;
  assign reg_wr    = accept & wbs_we_i & ~wbs_adr_i[ADDR_W+2];
  assign wr_idx    = wbs_adr_i[IDX_W+1:2];
  assign arm_req   = reg_wr && (wr_idx == '0) && wbs_dat_i[0];
  assign abort_req = reg_wr && (wr_idx == '0) && wbs_dat_i[1];
  assign done_o    = (state_q == S_DONE);

`ifdef LA_EDGE_TRIG_EN
  logic [31:0] edge_mask_q, probe_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      edge_mask_q <= '0;
      probe_q     <= '0;
    end else begin
      probe_q <= probe_i;
      if (reg_wr && wr_idx == IDX_W'(3)) edge_mask_q <= wbs_dat_i;
    end
  end

  assign trig_match = (((probe_i ^ trig_value_q) & trig_mask_q) == '0) &&
                      (((probe_i ^ probe_q) & edge_mask_q) == edge_mask_q);
`else
  assign trig_match = (((probe_i ^ trig_value_q) & trig_mask_q) == '0);
`endif

  always_comb begin
    state_d  = state_q;
    sample   = 1'b0;
    trig_hit = 1'b0;
    case (state_q)
      S_IDLE:  if (arm_req) state_d = S_ARMED;
      S_ARMED: begin
        sample = 1'b1;
        if (trig_match) begin
          trig_hit = 1'b1;
          state_d  = (post_len_q == '0) ? S_DONE : S_POST;
        end
      end
      // post counter reaching zero on this sample makes it the last one
      S_POST: begin
        sample = 1'b1;
        if (post_cnt_q == ADDR_W'(1)) state_d = S_DONE;
      end
      S_DONE:  if (arm_req) state_d = S_ARMED;
      default: state_d = S_IDLE;
    endcase
    if (abort_req) begin
      state_d  = S_IDLE;
      sample   = 1'b0;
      trig_hit = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      post_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (sample) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (abort_req) begin
        trig_ptr_q <= '0;
        post_cnt_q <= '0;
      end else if (trig_hit) begin
        trig_ptr_q <= wr_ptr_q;
        post_cnt_q <= post_len_q;
      end else if (state_q == S_POST) begin
        post_cnt_q <= post_cnt_q - 1'b1;
      end else if (arm_req) begin
        post_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      trig_mask_q  <= '0;
      trig_value_q <= '0;
      post_len_q   <= '0;
    end else if (reg_wr) begin
      if (wr_idx == IDX_W'(1)) trig_mask_q <= wbs_dat_i;
      if (wr_idx == IDX_W'(2)) trig_value_q <= wbs_dat_i;
      if (wr_idx == IDX_W'(POST_IDX)) post_len_q <= wbs_dat_i[ADDR_W-1:0];
    end
  end

  // k=0 maps to the slot about to be overwritten, i.e. the oldest sample
  assign rd_addr = wr_ptr_q + adr_q[ADDR_W-1:0];
  assign rd_idx  = adr_q[IDX_W-1:0];

  always_ff @(posedge clk_i) begin
    if (sample) mem[wr_ptr_q] <= probe_i;
    ram_q <= mem[rd_addr];
  end

  always_comb begin
    reg_rd = '0;
    if (rd_idx == '0) begin
      reg_rd[0]              = (state_q == S_ARMED) || (state_q == S_POST);
      reg_rd[1]              = (state_q == S_POST) || (state_q == S_DONE);
      reg_rd[2]              = (state_q == S_DONE);
      reg_rd[ADDR_W+15:16]   = trig_ptr_q;
    end else if (rd_idx == IDX_W'(1)) begin
      reg_rd = trig_mask_q;
    end else if (rd_idx == IDX_W'(2)) begin
      reg_rd = trig_value_q;
    end else if (rd_idx == IDX_W'(POST_IDX)) begin
      reg_rd[ADDR_W-1:0] = post_len_q;
`ifdef LA_EDGE_TRIG_EN
    end else if (rd_idx == IDX_W'(3)) begin
      reg_rd = edge_mask_q;
`endif
    end
  end

  // two-stage pipe: registered address, then synchronous RAM read
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stg1_q    <= 1'b0;
      stg2_q    <= 1'b0;
      adr_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      stg1_q    <= accept;
      stg2_q    <= stg1_q;
      wbs_ack_o <= stg2_q & wbs_cyc_i & wbs_stb_i;
      if (accept) adr_q <= wbs_adr_i[ADDR_W+2:2];
      if (stg2_q) wbs_dat_o <= adr_q[ADDR_W] ? ram_q : reg_rd;
    end
  end

endmodule
